// File: rtl/ibex_pkg.sv
// Shared types for the RVFI trace buffer: capture FSM encoding and the
// packed retirement record stored in the trace FIFO.
package ibex_pkg;

    typedef enum logic [1:0] {
        TRACE_IDLE      = 2'd0,
        TRACE_WAIT_TRIG = 2'd1,
        TRACE_CAPTURE   = 2'd2,
        TRACE_DONE      = 2'd3
    } trace_state_e;

    // 32 + 32 + 32 + 5 + 1 + 1 + 2 = 105 bits
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rd_wdata;
        logic [4:0]  rd_addr;
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
    } trace_rec_t;

    localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/ibex_trace_fifo.sv
// Generic synchronous FIFO with one-cycle write-to-read latency. A push while
// full is still accepted when a pop happens in the same cycle.
module ibex_trace_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CntW-1:0]  level_o
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push_acc, pop_acc;

    assign valid_o  = (cnt_q != '0);
    assign full_o   = (cnt_q == CntW'(Depth));
    assign pop_acc  = pop_i & valid_o;
    assign push_acc = push_i & (~full_o | pop_acc);
    assign level_o  = cnt_q;
    // Output is forced to zero when empty so reset leaves all record fields clear.
    assign rdata_o  = valid_o ? mem[rptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem[wptr_q] <= wdata_i;
        end
    end

    // Pointers are power-of-two wide, so increment wraps modulo Depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_acc) wptr_q <= wptr_q + 1'b1;
            if (pop_acc)  rptr_q <= rptr_q + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: PC-triggered capture session, privilege-mode
// filter, record FIFO and a saturating counter of records lost to a full buffer.
module ibex_rvfi_trace_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned Depth        = 16,
    parameter int unsigned DropCntWidth = 16,
    parameter bit          TriggerEn    = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         arm_i,
    input  logic                         stop_i,
    input  logic [31:0]                  trig_pc_i,
    input  logic [3:0]                   mode_mask_i,
    input  logic                         rvfi_valid,
    input  logic                         rvfi_trap,
    input  logic                         rvfi_intr,
    input  logic [1:0]                   rvfi_mode,
    input  logic [31:0]                  rvfi_pc_rdata,
    input  logic [31:0]                  rvfi_insn,
    input  logic [31:0]                  rvfi_rd_wdata,
    input  logic [4:0]                   rvfi_rd_addr,
    output logic                         rec_valid_o,
    input  logic                         rec_ready_i,
    output logic [31:0]                  rec_pc_o,
    output logic [31:0]                  rec_insn_o,
    output logic [31:0]                  rec_rd_wdata_o,
    output logic [4:0]                   rec_rd_addr_o,
    output logic [3:0]                   rec_flags_o,
    output logic [1:0]                   state_o,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic [DropCntWidth-1:0]      drop_cnt_o
);

    trace_state_e            state_q, state_d;
    logic                    trig_hit, capture_cand, arm_acc;
    logic                    push, pop, fifo_full, drop;
    trace_rec_t              rec_in, rec_out;
    logic [DropCntWidth-1:0] drop_cnt_q;

    assign trig_hit = rvfi_valid & (rvfi_pc_rdata == trig_pc_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= TRACE_IDLE;
        else       state_q <= state_d;
    end

    // stop_i takes priority over arm_i in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACE_IDLE, TRACE_DONE: begin
                if (arm_i && !stop_i) state_d = TriggerEn ? TRACE_WAIT_TRIG : TRACE_CAPTURE;
            end
            TRACE_WAIT_TRIG: begin
                if (stop_i)        state_d = TRACE_DONE;
                else if (trig_hit) state_d = TRACE_CAPTURE;
            end
            TRACE_CAPTURE: begin
                if (stop_i) state_d = TRACE_DONE;
            end
            default: state_d = TRACE_IDLE;
        endcase
    end

    // The triggering retirement is itself captured.
    always_comb begin
        capture_cand = 1'b0;
        arm_acc      = 1'b0;
        case (state_q)
            TRACE_IDLE, TRACE_DONE: arm_acc      = arm_i & ~stop_i;
            TRACE_WAIT_TRIG:        capture_cand = trig_hit;
            TRACE_CAPTURE:          capture_cand = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

    assign push = capture_cand & rvfi_valid & mode_mask_i[rvfi_mode] & ~rst_i;
    // Record handshake: a record moves when rec_valid_o && rec_ready_i at a rising
    // edge; rec_* hold while rec_valid_o is high and rec_ready_i is low.
    assign pop  = rec_valid_o & rec_ready_i;
    assign drop = push & fifo_full & ~pop;

    assign rec_in = '{pc:       rvfi_pc_rdata,
                      insn:     rvfi_insn,
                      rd_wdata: rvfi_rd_wdata,
                      rd_addr:  rvfi_rd_addr,
                      trap:     rvfi_trap,
                      intr:     rvfi_intr,
                      mode:     rvfi_mode};

    ibex_trace_fifo #(
        .Width (TRACE_REC_W),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (rec_in),
        .pop_i   (pop),
        .rdata_o (rec_out),
        .valid_o (rec_valid_o),
        .full_o  (fifo_full),
        .level_o (level_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || arm_acc)              drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end

    assign drop_cnt_o     = drop_cnt_q;
    assign rec_pc_o       = rec_out.pc;
    assign rec_insn_o     = rec_out.insn;
    assign rec_rd_wdata_o = rec_out.rd_wdata;
    assign rec_rd_addr_o  = rec_out.rd_addr;
    assign rec_flags_o    = {rec_out.trap, rec_out.intr, rec_out.mode};

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Directed bench for the RVFI trace buffer: trigger, mode filter, drops,
// full-buffer passthrough, stop/arm collision, saturation and reset.
module tb_ibex_rvfi_trace_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DCW   = 2;

    logic        clk = 1'b0;
    logic        rst_i, arm_i, stop_i;
    logic [31:0] trig_pc_i;
    logic [3:0]  mode_mask_i;
    logic        rvfi_valid, rvfi_trap, rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata;
    logic [4:0]  rvfi_rd_addr;
    logic        rec_valid_o, rec_ready_i;
    logic [31:0] rec_pc_o, rec_insn_o, rec_rd_wdata_o;
    logic [4:0]  rec_rd_addr_o;
    logic [3:0]  rec_flags_o;
    logic [1:0]  state_o;
    logic [2:0]  level_o;
    logic [1:0]  drop_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    ibex_rvfi_trace_buffer #(
        .Depth(DEPTH), .DropCntWidth(DCW), .TriggerEn(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .arm_i(arm_i), .stop_i(stop_i),
        .trig_pc_i(trig_pc_i), .mode_mask_i(mode_mask_i),
        .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
        .rvfi_mode(rvfi_mode), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_addr(rvfi_rd_addr),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_pc_o(rec_pc_o), .rec_insn_o(rec_insn_o), .rec_rd_wdata_o(rec_rd_wdata_o),
        .rec_rd_addr_o(rec_rd_addr_o), .rec_flags_o(rec_flags_o),
        .state_o(state_o), .level_o(level_o), .drop_cnt_o(drop_cnt_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic set_rvfi(input logic [31:0] pc, input logic [1:0] mode, input logic trap);
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = pc;
        rvfi_mode     = mode;
        rvfi_trap     = trap;
        rvfi_intr     = 1'b0;
        rvfi_insn     = pc ^ 32'h0000_0013;
        rvfi_rd_wdata = ~pc;
        rvfi_rd_addr  = pc[6:2];
    endtask

    task automatic retire(input logic [31:0] pc, input logic [1:0] mode, input logic trap);
        set_rvfi(pc, mode, trap);
        tick();
        rvfi_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1; tick(); arm_i = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
    endtask

    // Pops every expected record in order, bounded by a cycle budget.
    task automatic drain(input string name);
        int budget;
        budget = 32;
        rec_ready_i = 1'b1;
        while (exp_q.size() > 0 && budget > 0) begin
            checks++;
            if (rec_valid_o !== 1'b1 || rec_pc_o !== exp_q[0]) begin
                errors++;
                $display("FAIL %s_pc: valid=%b pc=%h, required valid=1 pc=%h", name, rec_valid_o, rec_pc_o, exp_q[0]);
            end
            checks++;
            if (rec_insn_o !== (exp_q[0] ^ 32'h13) || rec_rd_wdata_o !== ~exp_q[0] || rec_rd_addr_o !== exp_q[0][6:2]) begin
                errors++;
                $display("FAIL %s_fields: insn=%h wdata=%h rd=%0d for pc %h", name, rec_insn_o, rec_rd_wdata_o, rec_rd_addr_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
            budget--;
        end
        rec_ready_i = 1'b0;
        checks++;
        if (budget == 0 || rec_valid_o !== 1'b0 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL %s_empty: valid=%b level=%0d left=%0d, required valid=0 level=0", name, rec_valid_o, level_o, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
        checks++;
        if (state_o !== 2'd0 || level_o !== 3'd0 || rec_valid_o !== 1'b0 || drop_cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d level=%0d valid=%b drop=%0d, required all 0", state_o, level_o, rec_valid_o, drop_cnt_o);
        end
        checks++;
        if (rec_pc_o !== 32'h0 || rec_insn_o !== 32'h0 || rec_rd_wdata_o !== 32'h0 || rec_rd_addr_o !== 5'h0 || rec_flags_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_rec: pc=%h insn=%h wd=%h rd=%h flags=%h, required 0", rec_pc_o, rec_insn_o, rec_rd_wdata_o, rec_rd_addr_o, rec_flags_o);
        end
    endtask

    task automatic test_trigger();
        trig_pc_i = 32'h200; mode_mask_i = 4'b1000; rec_ready_i = 1'b0;
        pulse_arm();
        checks++;
        if (state_o !== 2'd1) begin errors++; $display("FAIL trig_arm: state=%0d, required 1", state_o); end
        retire(32'h100, 2'd3, 1'b0);
        checks++;
        if (state_o !== 2'd1 || level_o !== 3'd0) begin
            errors++; $display("FAIL trig_pre: state=%0d level=%0d, required 1/0", state_o, level_o);
        end
        retire(32'h200, 2'd3, 1'b0);
        exp_q.push_back(32'h200);
        checks++;
        if (state_o !== 2'd2 || level_o !== 3'd1 || rec_valid_o !== 1'b1 || rec_pc_o !== 32'h200) begin
            errors++; $display("FAIL trig_hit: state=%0d level=%0d valid=%b pc=%h, required 2/1/1/200", state_o, level_o, rec_valid_o, rec_pc_o);
        end
        retire(32'h204, 2'd3, 1'b0);
        exp_q.push_back(32'h204);
        checks++;
        if (level_o !== 3'd2) begin errors++; $display("FAIL trig_level: level=%0d, required 2", level_o); end
        drain("trig");
    endtask

    task automatic test_mode_filter();
        retire(32'h300, 2'd0, 1'b0);
        retire(32'h304, 2'd3, 1'b1);
        exp_q.push_back(32'h304);
        checks++;
        if (level_o !== 3'd1 || rec_pc_o !== 32'h304 || rec_flags_o !== 4'b1011) begin
            errors++; $display("FAIL mode_filter: level=%0d pc=%h flags=%b, required 1/304/1011", level_o, rec_pc_o, rec_flags_o);
        end
        drain("mode");
    endtask

    task automatic test_drop();
        rec_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            retire(32'h400 + 32'(4 * i), 2'd3, 1'b0);
            if (i < 4) exp_q.push_back(32'h400 + 32'(4 * i));
            checks++;
            if (rec_pc_o !== 32'h400) begin errors++; $display("FAIL drop_hold%0d: pc=%h, required 400", i, rec_pc_o); end
        end
        checks++;
        if (level_o !== 3'd4 || drop_cnt_o !== 2'd2) begin
            errors++; $display("FAIL drop_count: level=%0d drop=%0d, required 4/2", level_o, drop_cnt_o);
        end
        pulse_stop();
        checks++;
        if (state_o !== 2'd3) begin errors++; $display("FAIL drop_stop: state=%0d, required 3", state_o); end
        pulse_arm();
        checks++;
        if (state_o !== 2'd1 || drop_cnt_o !== 2'd0 || level_o !== 3'd4) begin
            errors++; $display("FAIL drop_rearm: state=%0d drop=%0d level=%0d, required 1/0/4", state_o, drop_cnt_o, level_o);
        end
    endtask

    task automatic test_full_passthrough();
        trig_pc_i = 32'h1000; rec_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_rvfi(32'h1000 + 32'(4 * i), 2'd3, 1'b0);
            checks++;
            if (rec_valid_o !== 1'b1 || rec_pc_o !== exp_q[0]) begin
                errors++; $display("FAIL pass_head%0d: valid=%b pc=%h, required 1/%h", i, rec_valid_o, rec_pc_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(32'h1000 + 32'(4 * i));
            tick();
            checks++;
            if (level_o !== 3'd4 || drop_cnt_o !== 2'd0) begin
                errors++; $display("FAIL pass_level%0d: level=%0d drop=%0d, required 4/0", i, level_o, drop_cnt_o);
            end
        end
        rvfi_valid = 1'b0;
        checks++;
        if (state_o !== 2'd2) begin errors++; $display("FAIL pass_state: state=%0d, required 2", state_o); end
        drain("pass");
    endtask

    task automatic test_stop_arm_same();
        set_rvfi(32'h500, 2'd3, 1'b0);
        arm_i = 1'b1; stop_i = 1'b1;
        tick();
        arm_i = 1'b0; stop_i = 1'b0; rvfi_valid = 1'b0;
        exp_q.push_back(32'h500);
        checks++;
        if (state_o !== 2'd3 || level_o !== 3'd1 || rec_pc_o !== 32'h500) begin
            errors++; $display("FAIL stoparm: state=%0d level=%0d pc=%h, required 3/1/500", state_o, level_o, rec_pc_o);
        end
        drain("stoparm");
    endtask

    task automatic test_sat_reset();
        trig_pc_i = 32'h2000;
        pulse_arm();
        for (int i = 0; i < 9; i++) retire(32'h2000 + 32'(4 * i), 2'd3, 1'b0);
        checks++;
        if (state_o !== 2'd2 || level_o !== 3'd4 || drop_cnt_o !== 2'd3) begin
            errors++; $display("FAIL sat: state=%0d level=%0d drop=%0d, required 2/4/3", state_o, level_o, drop_cnt_o);
        end
        rec_ready_i = 1'b1; tick(); rec_ready_i = 1'b0;
        checks++;
        if (level_o !== 3'd3 || rec_pc_o !== 32'h2004) begin
            errors++; $display("FAIL sat_pop: level=%0d pc=%h, required 3/2004", level_o, rec_pc_o);
        end
        set_rvfi(32'h3000, 2'd3, 1'b0);
        rst_i = 1'b1;
        tick();
        checks++;
        if (level_o !== 3'd0 || rec_valid_o !== 1'b0 || state_o !== 2'd0 || drop_cnt_o !== 2'd0 || rec_pc_o !== 32'h0) begin
            errors++; $display("FAIL mid_reset: level=%0d valid=%b state=%0d drop=%0d pc=%h, required all 0", level_o, rec_valid_o, state_o, drop_cnt_o, rec_pc_o);
        end
        rst_i = 1'b0; rvfi_valid = 1'b0;
        tick();
        checks++;
        if (level_o !== 3'd0 || state_o !== 2'd0) begin
            errors++; $display("FAIL post_reset: level=%0d state=%0d, required 0/0", level_o, state_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; arm_i = 1'b0; stop_i = 1'b0; trig_pc_i = '0; mode_mask_i = 4'b1000;
        rvfi_valid = 1'b0; rvfi_trap = 1'b0; rvfi_intr = 1'b0; rvfi_mode = '0;
        rvfi_pc_rdata = '0; rvfi_insn = '0; rvfi_rd_wdata = '0; rvfi_rd_addr = '0;
        rec_ready_i = 1'b0;
        test_reset();
        test_trigger();
        test_mode_filter();
        test_drop();
        test_full_passthrough();
        test_stop_arm_same();
        test_sat_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
